bankgroup_cmd_sequencer: RTL

//  Upstream command stage for one bank group. Accepts DDR-style commands (ACT/RD/WR/PRE/PREA).

---
 rtl/bg_pkg.sv | 23 ++
 rtl/bank_row_tracker.sv | 44 ++++
 rtl/bankgroup_cmd_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
// Shared types for the bank-group command sequencer.
// Command encoding, sequencer state and default burst sizing.
package bg_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ACT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        PRE  = 3'd4,
        PREA = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_RD = 2'd1,
        BURST_WR = 2'd2
    } seq_state_e;

    localparam int BL_DEFAULT = 8;
    localparam int BURST_BITS = $clog2(BL_DEFAULT);

endpackage

// File: rtl/bank_row_tracker.sv
// Per-bank open flag and open-row register.
// A close request (auto-precharge) behaves like a precharge.
module bank_row_tracker #(
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 act,
    input  logic                 pre,
    input  logic                 close,
    input  logic [ADDRWIDTH-1:0] row_in,
    output logic                 is_open,
    output logic [ADDRWIDTH-1:0] row_o
);

    logic                 open_q, open_d;
    logic [ADDRWIDTH-1:0] row_q, row_d;

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (act) begin
            open_d = 1'b1;
            row_d  = row_in;
        end
        if (pre || close) begin
            open_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= 1'b0;
            row_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    assign is_open = open_q;
    assign row_o   = row_q;

endmodule

// File: rtl/bankgroup_cmd_sequencer.sv
// Bank-group command sequencer: row tracking and BL-beat burst expansion.
// Optional auto-precharge on RD/WR via BGSEQ_AUTOPRE_EN.
module bankgroup_cmd_sequencer
    import bg_pkg::*;
#(
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = BL_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [2:0]                             cmd,
    input  logic [BAWIDTH-1:0]                     cmd_ba,
    input  logic [ADDRWIDTH-1:0]                   cmd_addr,
    input  logic [DEVICE_WIDTH-1:0]                wdata,
    output logic [DEVICE_WIDTH-1:0]                rdata,
    output logic                                   rvalid,
    output logic                                   cmd_err,
    output logic [2**BAWIDTH-1:0]                  open_mask,
    output logic [2**BAWIDTH-1:0]                  rd_o_wr,
    output logic [2**BAWIDTH*DEVICE_WIDTH-1:0]     dqin,
    input  logic [2**BAWIDTH*DEVICE_WIDTH-1:0]     dqout,
    output logic [2**BAWIDTH*ADDRWIDTH-1:0]        row,
    output logic [2**BAWIDTH*COLWIDTH-1:0]         column
);

    localparam int BANKS = 2**BAWIDTH;
    localparam int DW    = DEVICE_WIDTH;
    localparam int CW    = COLWIDTH;
    localparam int AW    = ADDRWIDTH;
    localparam int BB    = (BL == BL_DEFAULT) ? BURST_BITS : $clog2(BL);

`ifdef BGSEQ_AUTOPRE_EN
    if (ADDRWIDTH <= COLWIDTH) begin : g_bad_cfg
        $error("auto-precharge needs ADDRWIDTH > COLWIDTH");
    end
`endif

    seq_state_e           state_q, state_d;
    logic [BAWIDTH-1:0]   bsel_q, bsel_d;
    logic [BB-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        col_q [BANKS];
    logic [CW-1:0]        col_d [BANKS];
    logic                 ap_q, ap_d;
    logic                 err_q, err_d;
    logic                 rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [BANKS-1:0]     act_v, pre_v, close_v, open_v;
    logic [AW-1:0]        row_v [BANKS];
    logic                 last;

    assign last = (cnt_q == BB'(BL - 1));

    for (genvar i = 0; i < BANKS; i++) begin : g_bank
        bank_row_tracker #(.ADDRWIDTH(AW)) u_trk (
            .clk     (clk),
            .reset_n (reset_n),
            .act     (act_v[i]),
            .pre     (pre_v[i]),
            .close   (close_v[i]),
            .row_in  (cmd_addr),
            .is_open (open_v[i]),
            .row_o   (row_v[i])
        );
        assign row[i*AW +: AW]    = row_v[i];
        assign column[i*CW +: CW] = col_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bsel_q   <= '0;
            cnt_q    <= '0;
            ap_q     <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < BANKS; i++) col_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            bsel_q   <= bsel_d;
            cnt_q    <= cnt_d;
            ap_q     <= ap_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            col_q    <= col_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bsel_d   = bsel_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        ap_d     = ap_q;
        err_d    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        act_v    = '0;
        pre_v    = '0;
        close_v  = '0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        NOP: ;
                        ACT: begin
                            if (open_v[cmd_ba]) err_d = 1'b1;
                            else act_v[cmd_ba] = 1'b1;
                        end
                        RD, WR: begin
                            if (!open_v[cmd_ba]) begin
                                err_d = 1'b1;
                            end else begin
                                state_d        = (cmd == RD) ? BURST_RD : BURST_WR;
                                bsel_d         = cmd_ba;
                                cnt_d          = '0;
                                col_d[cmd_ba]  = cmd_addr[CW-1:0];
`ifdef BGSEQ_AUTOPRE_EN
                                ap_d           = cmd_addr[CW];
`else
                                ap_d           = 1'b0;
`endif
                            end
                        end
                        PRE:     pre_v[cmd_ba] = 1'b1;
                        PREA:    pre_v = '1;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            BURST_RD, BURST_WR: begin
                cnt_d = cnt_q + BB'(1);
                if (state_q == BURST_RD) begin
                    rvalid_d = 1'b1;
                    rdata_d  = dqout[bsel_q*DW +: DW];
                end
                // wrap inside the BL-aligned block; upper column bits never carry
                if (last) begin
                    state_d         = IDLE;
                    close_v[bsel_q] = ap_q;
                end else begin
                    col_d[bsel_q][BB-1:0] = col_q[bsel_q][BB-1:0] + BB'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rd_o_wr   = '0;
        dqin      = '0;
        if (state_q == BURST_WR) begin
            rd_o_wr[bsel_q]         = 1'b1;
            dqin[bsel_q*DW +: DW]   = wdata;
        end
    end

    assign open_mask = open_v;
    assign cmd_err   = err_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

endmodule
